godai_trace_buffer: RTL

GODAI_TRACE_BUFFER -- requirements
Module: godai_trace_buffer

---
 rtl/godai_trace_buffer.sv | 107 ++++++++++
 1 files changed

// File: rtl/godai_trace_buffer.sv
// Core trace capture buffer: timestamps non-zero event vectors into a FIFO and flags lost records.
// Optional macro GODAI_TRACE_TIMESTAMP_EN builds the free-running timestamp counter.
module godai_trace_buffer #(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     trace_en_i,
  input  logic [9:0]               event_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [TS_WIDTH+10:0]     trace_data_o,
  output logic [15:0]              drop_count_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
  output logic                     busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_WIDTH + 11;
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [RW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         level;
  logic                pend_drop;
  logic [15:0]         drop_cnt;
  logic [TS_WIDTH-1:0] ts;
  logic                empty, full, capture, pop, push, drop;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef GODAI_TRACE_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + TS_WIDTH'(1);
  end
`else
  assign ts = '0;
`endif

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign capture = (state == RUN) && (event_i != 10'd0);
  assign pop     = !empty && trace_ready_i;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push    = capture && (!full || pop);
  assign drop    = capture && !push;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trace_en_i) state_nxt = RUN;
      RUN:     if (!trace_en_i) state_nxt = DRAIN;
      DRAIN: begin
        if (trace_en_i)  state_nxt = RUN;
        else if (empty)  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pend_drop <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level <= level + LVL_ONE;
      else if (pop && !push) level <= level - LVL_ONE;
      if (drop) begin
        drop_cnt  <= sat_inc16(drop_cnt);
        pend_drop <= 1'b1;
      end else if (push) begin
        pend_drop <= 1'b0;
      end
    end
  end

  // Storage is data-only and left unreset; contents are qualified by the level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pend_drop, event_i, ts};
  end

  assign trace_valid_o = !empty;
  assign trace_data_o  = mem[rd_ptr];
  assign drop_count_o  = drop_cnt;
  assign fifo_level_o  = level;
  assign busy_o        = (state != IDLE);

endmodule
